// File: rtl/cache_arbiter_pkg.sv
// Shared cache types: arbiter FSM states, port-select type, default widths
// and the round-robin pick rule used by cache_arbiter.
package cache_arbiter_pkg;

  localparam int unsigned LINE_WIDTH_DEF = 256;
  localparam int unsigned ADDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_t;

  // Pick a port among the current requesters; on contention the port not
  // granted last wins.
  function automatic arb_sel_t arb_pick(input logic i_req, input logic d_req,
                                        input arb_sel_t last);
    arb_sel_t pick;
    if (i_req && d_req) begin
      if (last == SEL_I) pick = SEL_D;
      else               pick = SEL_I;
    end else if (d_req) begin
      pick = SEL_D;
    end else begin
      pick = SEL_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates line reads/writes from the split I- and D-caches onto a single
// physical memory port. One transaction at a time, no preemption, round-robin
// on contention.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   i_read/i_write/i_address/i_wdata  I-cache request (held until i_resp)
//   i_rdata, i_resp                   I-cache returned line and done pulse
//   d_*                               D-cache port, same meaning as i_*
//   pmem_read/pmem_write/pmem_address/pmem_wdata  memory request (registered)
//   pmem_rdata, pmem_resp             memory returned line and done pulse
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state, state_next;
  // Port of the current/last grant; doubles as the round-robin pointer.
  arb_sel_t   grant, grant_next;
  arb_sel_t   pick;

  logic [LINE_WIDTH-1:0] line, line_next;
  logic                  pmem_read_next, pmem_write_next;
  logic [ADDR_WIDTH-1:0] pmem_address_next;
  logic [LINE_WIDTH-1:0] pmem_wdata_next;
  logic                  i_resp_next, d_resp_next;

  logic i_req, d_req;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign pick  = arb_pick(i_req, d_req, grant);

  // Both caches see the captured line; only their resp qualifies it.
  assign i_rdata = line;
  assign d_rdata = line;

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= SEL_I;
      line         <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      state        <= state_next;
      grant        <= grant_next;
      line         <= line_next;
      pmem_read    <= pmem_read_next;
      pmem_write   <= pmem_write_next;
      pmem_address <= pmem_address_next;
      pmem_wdata   <= pmem_wdata_next;
      i_resp       <= i_resp_next;
      d_resp       <= d_resp_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next        = state;
    grant_next        = grant;
    line_next         = line;
    pmem_read_next    = pmem_read;
    pmem_write_next   = pmem_write;
    pmem_address_next = pmem_address;
    pmem_wdata_next   = pmem_wdata;
    i_resp_next       = 1'b0;
    d_resp_next       = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_next = pick;
          // A port with read and write both high is treated as a write.
          if (pick == SEL_D) begin
            pmem_write_next   = d_write;
            pmem_read_next    = ~d_write;
            pmem_address_next = d_address;
            pmem_wdata_next   = d_wdata;
          end else begin
            pmem_write_next   = i_write;
            pmem_read_next    = ~i_write;
            pmem_address_next = i_address;
            pmem_wdata_next   = i_wdata;
          end
          state_next = SERVE;
        end
      end

      SERVE: begin
        if (pmem_resp) begin
          line_next       = pmem_rdata;
          pmem_read_next  = 1'b0;
          pmem_write_next = 1'b0;
          i_resp_next     = (grant == SEL_I);
          d_resp_next     = (grant == SEL_D);
          state_next      = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next      = IDLE;
        pmem_read_next  = 1'b0;
        pmem_write_next = 1'b0;
      end
    endcase
  end

endmodule
